// File: rtl/life_stats_if.sv
// ---------------------------------------------------------------------------
// life_stats_if
//   Generation byte stream from the life engine into the statistics block.
//
//   enable      : life engine running; when low the stream is ignored
//   frame_start : one-cycle pulse ahead of a generation's first byte
//   byte_valid  : one-cycle strobe, byte_data holds eight next-gen cells
//   byte_data   : eight cells, 1 = live
//
//   master : the life engine (drives the stream)
//   slave  : life_stats (consumes the stream)
// ---------------------------------------------------------------------------
interface life_stats_if;
    logic       enable;
    logic       frame_start;
    logic       byte_valid;
    logic [7:0] byte_data;

    modport master (
        output enable,
        output frame_start,
        output byte_valid,
        output byte_data
    );

    modport slave (
        input enable,
        input frame_start,
        input byte_valid,
        input byte_data
    );
endinterface

// File: rtl/life_stats.sv
// ---------------------------------------------------------------------------
// life_stats
//   Per-generation statistics for the life engine. Each frame of
//   FRAME_BYTES bytes is reduced to a live-cell population and a
//   CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first). A frame that closes
//   with exactly FRAME_BYTES bytes is "good" and produces a snapshot; short
//   or overlong frames are discarded with an err_frame pulse. The CRCs of
//   the last two good frames are kept to flag still-lifes (stable) and
//   blinkers (period2); an empty board flags extinct.
//
//   clk_pixel   : pixel clock, the only clock
//   rst_n       : asynchronous active-low reset
//   strm        : generation byte stream (life_stats_if.slave)
//   irq_en      : interrupt enable
//   irq_ack     : one-cycle pulse clearing irq
//   gen_clr     : synchronous clear of generation
//   population  : live-cell count of the last good frame
//   generation  : count of good frames (wraps)
//   crc         : CRC of the last good frame
//   stable      : last good frame equals the one before it
//   period2     : last good frame equals the one two back, not the one before
//   extinct     : last good frame had no live cells
//   stats_valid : one-cycle pulse when the snapshot outputs update
//   err_frame   : one-cycle pulse when a frame is discarded
//   irq         : sticky interrupt
// ---------------------------------------------------------------------------
module life_stats #(
    parameter int unsigned FRAME_BYTES = 60000
) (
    input  logic              clk_pixel,
    input  logic              rst_n,
    life_stats_if.slave       strm,
    input  logic              irq_en,
    input  logic              irq_ack,
    input  logic              gen_clr,
    output logic [19:0]       population,
    output logic [15:0]       generation,
    output logic [15:0]       crc,
    output logic              stable,
    output logic              period2,
    output logic              extinct,
    output logic              stats_valid,
    output logic              err_frame,
    output logic              irq
);

    localparam logic [16:0] FRAME_CNT = 17'(FRAME_BYTES);
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        ACCUM     = 1'b1
    } state_t;

    state_t      state;
    logic [19:0] acc;
    logic [15:0] crc_acc;
    logic [16:0] byte_cnt;
    logic        bad;
    logic [15:0] hist0;     // CRC of the previous good frame
    logic [15:0] hist1;     // CRC of the good frame before that
    logic [1:0]  hist_cnt;

    function automatic logic [3:0] popcount8(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, b[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in,
                                               input logic [7:0]  d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[15] ^ d[7 - i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    logic [19:0] byte_pop;
    logic [15:0] crc_step;
    logic [15:0] crc_first;
    logic        frame_good;
    logic        snap_stable;
    logic        snap_period2;
    logic        snap_extinct;

    // Popcount is combinational, so a byte on the cycle just before
    // frame_start is already in acc when the snapshot is taken.
    always_comb begin
        byte_pop     = 20'(popcount8(strm.byte_data));
        crc_step     = crc16_byte(crc_acc, strm.byte_data);
        crc_first    = crc16_byte(CRC_INIT, strm.byte_data);
        frame_good   = (byte_cnt == FRAME_CNT) && !bad;
        snap_extinct = (acc == '0);
        snap_stable  = (hist_cnt != 2'd0) && (crc_acc == hist0);
        snap_period2 = (hist_cnt == 2'd2) && (crc_acc != hist0) &&
                       (crc_acc == hist1);
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_SYNC;
            acc         <= '0;
            crc_acc     <= CRC_INIT;
            byte_cnt    <= '0;
            bad         <= 1'b0;
            hist0       <= '0;
            hist1       <= '0;
            hist_cnt    <= '0;
            population  <= '0;
            generation  <= '0;
            crc         <= '0;
            stable      <= 1'b0;
            period2     <= 1'b0;
            extinct     <= 1'b0;
            stats_valid <= 1'b0;
            err_frame   <= 1'b0;
            irq         <= 1'b0;
        end else begin
            stats_valid <= 1'b0;
            err_frame   <= 1'b0;

            // Later assignments in this block take priority: a snapshot
            // increment is overridden by gen_clr, an ack by an irq set.
            if (irq_ack) begin
                irq <= 1'b0;
            end

            if (!strm.enable) begin
                state    <= WAIT_SYNC;
                acc      <= '0;
                crc_acc  <= CRC_INIT;
                byte_cnt <= '0;
                bad      <= 1'b0;
                hist_cnt <= '0;
            end else if (strm.frame_start) begin
                if (state == ACCUM) begin
                    if (frame_good) begin
                        population  <= acc;
                        crc         <= crc_acc;
                        stable      <= snap_stable;
                        period2     <= snap_period2;
                        extinct     <= snap_extinct;
                        stats_valid <= 1'b1;
                        generation  <= generation + 16'd1;
                        hist1       <= hist0;
                        hist0       <= crc_acc;
                        if (hist_cnt != 2'd2) begin
                            hist_cnt <= hist_cnt + 2'd1;
                        end
                        if (irq_en && (snap_stable || snap_period2 || snap_extinct)) begin
                            irq <= 1'b1;
                        end
                    end else begin
                        err_frame <= 1'b1;
                        hist_cnt  <= '0;
                    end
                end
                // A byte coincident with frame_start opens the new frame.
                state    <= ACCUM;
                bad      <= 1'b0;
                if (strm.byte_valid) begin
                    acc      <= byte_pop;
                    crc_acc  <= crc_first;
                    byte_cnt <= 17'd1;
                end else begin
                    acc      <= '0;
                    crc_acc  <= CRC_INIT;
                    byte_cnt <= '0;
                end
            end else if (strm.byte_valid && (state == ACCUM)) begin
                if (byte_cnt < FRAME_CNT) begin
                    acc      <= acc + byte_pop;
                    crc_acc  <= crc_step;
                    byte_cnt <= byte_cnt + 17'd1;
                end else begin
                    bad <= 1'b1;
                    if (byte_cnt != '1) begin
                        byte_cnt <= byte_cnt + 17'd1;
                    end
                end
            end

            if (gen_clr) begin
                generation <= '0;
            end
        end
    end

endmodule

// File: tb/tb_life_stats.sv
// ---------------------------------------------------------------------------
// tb_life_stats
//   Directed bench for life_stats with FRAME_BYTES = 4. A frame-level
//   reference model pushes each expected snapshot into a queue when the
//   closing frame_start is driven; snapshots are popped and compared when
//   stats_valid is seen. Held outputs and pulses are checked every cycle.
// ---------------------------------------------------------------------------
module tb_life_stats;

    localparam int unsigned FB = 4;

    logic clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    logic        rst_n;
    logic        irq_en;
    logic        irq_ack;
    logic        gen_clr;
    logic [19:0] population;
    logic [15:0] generation;
    logic [15:0] crc;
    logic        stable;
    logic        period2;
    logic        extinct;
    logic        stats_valid;
    logic        err_frame;
    logic        irq;

    life_stats_if sif ();

    life_stats #(.FRAME_BYTES(FB)) dut (
        .clk_pixel   (clk_pixel),
        .rst_n       (rst_n),
        .strm        (sif.slave),
        .irq_en      (irq_en),
        .irq_ack     (irq_ack),
        .gen_clr     (gen_clr),
        .population  (population),
        .generation  (generation),
        .crc         (crc),
        .stable      (stable),
        .period2     (period2),
        .extinct     (extinct),
        .stats_valid (stats_valid),
        .err_frame   (err_frame),
        .irq         (irq)
    );

    typedef struct packed {
        logic [19:0] pop;
        logic [15:0] gen;
        logic [15:0] crc;
        logic        st;
        logic        p2;
        logic        ex;
    } snap_t;

    snap_t sb[$];

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit          m_accum;
    bit          m_bad;
    int unsigned m_pop;
    int unsigned m_cnt;
    logic [15:0] m_crc;
    logic [15:0] h0, h1;
    int          hc;
    logic [15:0] m_gen;
    logic        m_irq;
    logic [19:0] o_pop;
    logic [15:0] o_crc;

    function automatic logic [15:0] crc_ref(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int k = 7; k >= 0; k--) begin
            if (c[15] != d[k]) c = (c << 1) ^ 16'h1021;
            else               c = c << 1;
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_byte(input logic [7:0] d);
        if (m_cnt < FB) begin
            m_pop = m_pop + $countones(d);
            m_crc = crc_ref(m_crc, d);
        end else begin
            m_bad = 1'b1;
        end
        m_cnt++;
    endtask

    task automatic tick(input logic fs, input logic bv, input logic [7:0] d);
        bit    exp_sv;
        bit    exp_err;
        bit    irq_set;
        snap_t s;
        exp_sv  = 1'b0;
        exp_err = 1'b0;
        irq_set = 1'b0;
        sif.frame_start = fs;
        sif.byte_valid  = bv;
        sif.byte_data   = d;

        if (!sif.enable) begin
            m_accum = 1'b0;
            hc      = 0;
        end else if (fs) begin
            if (m_accum) begin
                if (m_cnt == FB && !m_bad) begin
                    s.pop = 20'(m_pop);
                    s.crc = m_crc;
                    s.ex  = (m_pop == 0);
                    s.st  = (hc >= 1) && (m_crc == h0);
                    s.p2  = (hc == 2) && (m_crc != h0) && (m_crc == h1);
                    m_gen = m_gen + 16'd1;
                    if (gen_clr) m_gen = 16'd0;
                    s.gen = m_gen;
                    h1 = h0;
                    h0 = m_crc;
                    if (hc < 2) hc++;
                    if (irq_en && (s.st || s.p2 || s.ex)) irq_set = 1'b1;
                    sb.push_back(s);
                    exp_sv = 1'b1;
                    o_pop  = s.pop;
                    o_crc  = s.crc;
                end else begin
                    exp_err = 1'b1;
                    hc      = 0;
                end
            end
            m_accum = 1'b1;
            m_bad   = 1'b0;
            m_pop   = 0;
            m_cnt   = 0;
            m_crc   = 16'hFFFF;
            if (bv) add_byte(d);
        end else if (bv && m_accum) begin
            add_byte(d);
        end
        if (gen_clr) m_gen = 16'd0;
        if (irq_set)      m_irq = 1'b1;
        else if (irq_ack) m_irq = 1'b0;

        @(posedge clk_pixel);
        #1;
        sif.frame_start = 1'b0;
        sif.byte_valid  = 1'b0;
        gen_clr         = 1'b0;
        irq_ack         = 1'b0;

        chk("stats_valid", 32'(stats_valid), 32'(exp_sv));
        chk("err_frame",   32'(err_frame),   32'(exp_err));
        chk("irq",         32'(irq),         32'(m_irq));
        chk("generation",  32'(generation),  32'(m_gen));
        chk("population_hold", 32'(population), 32'(o_pop));
        chk("crc_hold",    32'(crc),         32'(o_crc));
        if (stats_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_snapshot", 32'(sb.size()), 32'd1);
            end else begin
                s = sb.pop_front();
                chk("snap_population", 32'(population), 32'(s.pop));
                chk("snap_generation", 32'(generation), 32'(s.gen));
                chk("snap_crc",        32'(crc),        32'(s.crc));
                chk("snap_stable",     32'(stable),     32'(s.st));
                chk("snap_period2",    32'(period2),    32'(s.p2));
                chk("snap_extinct",    32'(extinct),    32'(s.ex));
            end
        end
    endtask

    task automatic fs_only();
        tick(1'b1, 1'b0, 8'h00);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic bytes4(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
        tick(1'b0, 1'b1, b0);
        tick(1'b0, 1'b1, b1);
        tick(1'b0, 1'b1, b2);
        tick(1'b0, 1'b1, b3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_population",  32'(population),  32'd0);
        chk("rst_generation",  32'(generation),  32'd0);
        chk("rst_crc",         32'(crc),         32'd0);
        chk("rst_stable",      32'(stable),      32'd0);
        chk("rst_period2",     32'(period2),     32'd0);
        chk("rst_extinct",     32'(extinct),     32'd0);
        chk("rst_stats_valid", 32'(stats_valid), 32'd0);
        chk("rst_err_frame",   32'(err_frame),   32'd0);
        chk("rst_irq",         32'(irq),         32'd0);
        m_accum = 1'b0;
        m_bad   = 1'b0;
        m_pop   = 0;
        m_cnt   = 0;
        m_crc   = 16'hFFFF;
        hc      = 0;
        h0      = '0;
        h1      = '0;
        m_gen   = '0;
        m_irq   = 1'b0;
        o_pop   = '0;
        o_crc   = '0;
        @(posedge clk_pixel);
        @(posedge clk_pixel);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b1;
        irq_en          = 1'b0;
        irq_ack         = 1'b0;
        gen_clr         = 1'b0;
        sif.enable      = 1'b0;
        sif.frame_start = 1'b0;
        sif.byte_valid  = 1'b0;
        sif.byte_data   = 8'h00;
        #2;
        do_reset();
        sif.enable = 1'b1;

        // first frame: population 10, generation 1
        fs_only();
        bytes4(8'hFF, 8'h01, 8'h00, 8'h80);
        fs_only();
        idle();

        // same frame twice more: stable, irq until ack
        irq_en = 1'b1;
        bytes4(8'hFF, 8'h01, 8'h00, 8'h80);
        fs_only();
        bytes4(8'hFF, 8'h01, 8'h00, 8'h80);
        fs_only();
        idle();
        idle();
        irq_ack = 1'b1;
        idle();
        irq_en = 1'b0;

        // alternating A/B: third snapshot of the series is period2
        bytes4(8'hFF, 8'h00, 8'h00, 8'h00);
        fs_only();
        bytes4(8'h00, 8'hFF, 8'h00, 8'h00);
        fs_only();
        bytes4(8'hFF, 8'h00, 8'h00, 8'h00);
        fs_only();
        bytes4(8'h00, 8'hFF, 8'h00, 8'h00);
        fs_only();

        // short then long frame: two discards, history cleared
        tick(1'b0, 1'b1, 8'h11);
        tick(1'b0, 1'b1, 8'h22);
        tick(1'b0, 1'b1, 8'h33);
        fs_only();
        bytes4(8'h01, 8'h02, 8'h04, 8'h08);
        tick(1'b0, 1'b1, 8'h10);
        fs_only();
        bytes4(8'hFF, 8'h00, 8'h00, 8'h00);
        fs_only();
        bytes4(8'hFF, 8'h00, 8'h00, 8'h00);
        fs_only();

        // last byte just before frame_start, byte coincident with frame_start
        tick(1'b0, 1'b1, 8'h01);
        tick(1'b0, 1'b1, 8'h03);
        tick(1'b0, 1'b1, 8'h07);
        tick(1'b0, 1'b1, 8'h0F);
        tick(1'b1, 1'b1, 8'hF0);
        tick(1'b0, 1'b1, 8'h00);
        tick(1'b0, 1'b1, 8'h00);
        tick(1'b0, 1'b1, 8'h01);
        gen_clr = 1'b1;          // clear wins over the snapshot increment
        fs_only();
        bytes4(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        fs_only();
        gen_clr = 1'b1;
        idle();

        // enable dropped mid-frame: stream ignored, resync without snapshot
        tick(1'b0, 1'b1, 8'hAA);
        tick(1'b0, 1'b1, 8'hBB);
        sif.enable = 1'b0;
        tick(1'b0, 1'b1, 8'hCC);
        tick(1'b1, 1'b1, 8'h55);
        idle();
        sif.enable = 1'b1;
        fs_only();
        bytes4(8'h0A, 8'h0B, 8'h0C, 8'h0D);
        fs_only();

        // all-zero frame: extinct and irq
        irq_en = 1'b1;
        bytes4(8'h00, 8'h00, 8'h00, 8'h00);
        fs_only();
        idle();

        // reset mid-frame: outputs cleared, next frame_start gives no snapshot
        tick(1'b0, 1'b1, 8'h5A);
        tick(1'b0, 1'b1, 8'hA5);
        do_reset();
        fs_only();
        bytes4(8'h12, 8'h34, 8'h56, 8'h78);
        fs_only();
        idle();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
